// File: rtl/kamus_pkg.sv
// kamus_pkg: shared types and constants for the kamus-v memory stage.
//   mem_op_e    : memory operation encoding carried from EX (4 bits)
//   EXC_*       : mcause codes raised with a writeback record
//   is_load / is_store / op_misaligned : small decode helpers
package kamus_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    function automatic logic is_load(input mem_op_e op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Halfwords need a[0]==0, words need a[1:0]==0; bytes are always aligned.
    function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] lo);
        logic r;
        r = 1'b0;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: r = lo[0];
            MEM_LW, MEM_SW:          r = |lo;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/kamus_mem_align.sv
// kamus_mem_align: combinational lane logic for data-memory accesses.
//   op         in  4   mem_op_e of the access
//   addr_lo    in  2   effective address bits [1:0]
//   store_data in  32  rs2 value to be stored
//   rdata      in  32  word returned by data memory
//   be         out 4   byte enables (all ones for loads and words)
//   wdata      out 32  store data replicated across lanes
//   load_data  out 32  selected lane, sign/zero extended per op
// Halfword lane selection uses addr_lo[1] only and words ignore addr_lo,
// so misaligned offsets are silently rounded down here.
module kamus_mem_align
    import kamus_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    mem_op_e     op_e;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign op_e      = mem_op_e'(op);
    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = '1;
        wdata     = store_data;
        load_data = rdata;
        case (op_e)
            MEM_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MEM_SH: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            MEM_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
            MEM_LBU: load_data = {24'h000000, byte_lane};
            MEM_LH:  load_data = {{16{half_lane[15]}}, half_lane};
            MEM_LHU: load_data = {16'h0000, half_lane};
            default: ;
        endcase
    end

endmodule

// File: rtl/kamus_mem.sv
// kamus_mem: memory-access stage of the kamus-v core.
// Accepts an EX result (ALU value or effective address), performs the data
// memory access over a req/gnt/rvalid bus and produces a registered
// writeback record with a one-cycle wb_valid_o pulse.
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   valid_i/ready_o               issue handshake from EX (ready only in IDLE)
//   mem_op_i, ex_i, store_data_i  operation, address/ALU value, rs2 data
//   rd_i, rd_we_i                 destination register and its write enable
//   dmem_*                        data memory request/grant/response bus
//   wb_*                          writeback record
//   exc_o, exc_cause_o            exception flag and mcause code
// Parameter TIMEOUT_CYCLES: cycles allowed in REQ or WAIT_R before an
// access fault (0 disables).
// Build option KAMUS_MISALIGN_TRAP_EN: trap misaligned halfword/word
// accesses without touching the bus; otherwise low bits are ignored.
module kamus_mem
    import kamus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] ex_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_i,
    input  logic        rd_we_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_we_o,
    output logic        exc_o,
    output logic [3:0]  exc_cause_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R
    } state_e;

    state_e        state;
    logic [3:0]    op_q;
    logic [1:0]    lo_q;
    logic [4:0]    rd_q;
    logic          rd_we_q;
    logic          st_q;
    logic [CW-1:0] tmo_cnt;

    mem_op_e       in_op;
    logic          in_mem;
    logic          in_store;
    logic          trap_misalign;
    logic          tmo_hit;
    logic [3:0]    al_op;
    logic [1:0]    al_lo;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_load;

    assign in_op    = mem_op_e'(mem_op_i);
    assign in_store = is_store(in_op);
    assign in_mem   = is_load(in_op) || in_store;

`ifdef KAMUS_MISALIGN_TRAP_EN
    assign trap_misalign = op_misaligned(in_op, ex_i[1:0]);
`else
    assign trap_misalign = 1'b0;
`endif

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // One aligner serves both directions: in IDLE it forms store lanes from
    // the incoming instruction, afterwards it extracts from the latched op.
    assign al_op = (state == S_IDLE) ? mem_op_i  : op_q;
    assign al_lo = (state == S_IDLE) ? ex_i[1:0] : lo_q;

    kamus_mem_align u_align (
        .op         (al_op),
        .addr_lo    (al_lo),
        .store_data (store_data_i),
        .rdata      (dmem_rdata_i),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            op_q         <= '0;
            lo_q         <= '0;
            rd_q         <= '0;
            rd_we_q      <= 1'b0;
            st_q         <= 1'b0;
            tmo_cnt      <= '0;
            ready_o      <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= '0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            wb_data_o    <= '0;
            wb_rd_o      <= '0;
            wb_we_o      <= 1'b0;
            exc_o        <= 1'b0;
            exc_cause_o  <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            exc_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b1;
                    if (valid_i && ready_o) begin
                        if (in_mem && trap_misalign) begin
                            wb_valid_o  <= 1'b1;
                            wb_data_o   <= '0;
                            wb_rd_o     <= rd_i;
                            wb_we_o     <= 1'b0;
                            exc_o       <= 1'b1;
                            exc_cause_o <= in_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                        end else if (in_mem) begin
                            op_q         <= mem_op_i;
                            lo_q         <= ex_i[1:0];
                            rd_q         <= rd_i;
                            rd_we_q      <= rd_we_i;
                            st_q         <= in_store;
                            tmo_cnt      <= '0;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= in_store;
                            dmem_be_o    <= al_be;
                            dmem_addr_o  <= {ex_i[31:2], 2'b00};
                            dmem_wdata_o <= al_wdata;
                            ready_o      <= 1'b0;
                            state        <= S_REQ;
                        end else begin
                            wb_valid_o <= 1'b1;
                            wb_data_o  <= ex_i;
                            wb_rd_o    <= rd_i;
                            wb_we_o    <= rd_we_i;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (st_q) begin
                            wb_valid_o <= 1'b1;
                            wb_data_o  <= '0;
                            wb_rd_o    <= rd_q;
                            wb_we_o    <= 1'b0;
                            ready_o    <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= S_WAIT_R;
                        end
                    end else if (tmo_hit) begin
                        dmem_req_o  <= 1'b0;
                        wb_valid_o  <= 1'b1;
                        wb_data_o   <= '0;
                        wb_rd_o     <= rd_q;
                        wb_we_o     <= 1'b0;
                        exc_o       <= 1'b1;
                        exc_cause_o <= st_q ? EXC_ST_FAULT : EXC_LD_FAULT;
                        ready_o     <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                S_WAIT_R: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_o <= 1'b1;
                        wb_data_o  <= al_load;
                        wb_rd_o    <= rd_q;
                        wb_we_o    <= rd_we_q;
                        ready_o    <= 1'b1;
                        state      <= S_IDLE;
                    end else if (tmo_hit) begin
                        wb_valid_o  <= 1'b1;
                        wb_data_o   <= '0;
                        wb_rd_o     <= rd_q;
                        wb_we_o     <= 1'b0;
                        exc_o       <= 1'b1;
                        exc_cause_o <= EXC_LD_FAULT;
                        ready_o     <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kamus_mem.sv
// tb_kamus_mem: randomized bench for kamus_mem with an in-bench reference
// model of lane formation, load extension, timeout and misalignment rules.
module tb_kamus_mem;
    import kamus_pkg::*;

    localparam int unsigned TMO = 8;
`ifdef KAMUS_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  mem_op_i = '0;
    logic [31:0] ex_i = '0;
    logic [31:0] store_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic        rd_we_i = 1'b0;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_we_o;
    logic        exc_o;
    logic [3:0]  exc_cause_o;

    kamus_mem #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .mem_op_i      (mem_op_i),
        .ex_i          (ex_i),
        .store_data_i  (store_data_i),
        .rd_i          (rd_i),
        .rd_we_i       (rd_we_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_data_o     (wb_data_o),
        .wb_rd_o       (wb_rd_o),
        .wb_we_o       (wb_we_o),
        .exc_o         (exc_o),
        .exc_cause_o   (exc_cause_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected state, written by the driver at #1 after each rising edge.
    bit          check_en = 1'b0;
    bit          exp_busy = 1'b1;
    bit          exp_req = 1'b0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;
    int          wb_push = 0;
    int          wb_pop = 0;
    logic [31:0] exp_wb_data;
    logic [4:0]  exp_wb_rd;
    logic        exp_wb_we, exp_wb_exc, exp_wb_chkdata;
    logic [3:0]  exp_wb_cause;
    logic [31:0] last_req_addr = '0, last_req_wdata = '0;
    logic [3:0]  last_req_be = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned m_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic bit m_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic int unsigned m_off(input logic [3:0] op, input logic [31:0] a);
        int unsigned o = a % 4;
        return o - (o % m_size(op));
    endfunction

    function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] a);
        return ((a % 4) % m_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        int unsigned v = ((1 << m_size(op)) - 1) << m_off(op, a);
        if (m_is_load(op)) return 4'hF;
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] r = '0;
        int unsigned s = m_size(op);
        for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(b % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] r);
        int unsigned s = m_size(op);
        logic [31:0] v = r >> (8 * m_off(op, a));
        logic [31:0] mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 1);
        v = v & mask;
        if ((op == MEM_LB || op == MEM_LH) && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic push_wb(input logic [31:0] d, input logic [4:0] rd, input logic we,
                           input logic exc, input logic [3:0] cause, input logic chkd);
        exp_wb_data = d; exp_wb_rd = rd; exp_wb_we = we;
        exp_wb_exc = exc; exp_wb_cause = cause; exp_wb_chkdata = chkd;
        wb_push++;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit pend;
        if (check_en) begin
            pend = (wb_push != wb_pop);
            wb_pop = wb_push;
            chk("ready", 32'(ready_o), 32'(!exp_busy));
            chk("req", 32'(dmem_req_o), 32'(exp_req));
            if (exp_req && dmem_req_o) begin
                chk("addr", dmem_addr_o, exp_addr);
                chk("we", 32'(dmem_we_o), 32'(exp_we));
                chk("be", 32'(dmem_be_o), 32'(exp_be));
                if (exp_we) chk("wdata", dmem_wdata_o, exp_wdata);
            end
            if (dmem_req_o) begin
                last_req_addr = dmem_addr_o;
                last_req_be = dmem_be_o;
                last_req_wdata = dmem_wdata_o;
            end
            chk("wb_valid", 32'(wb_valid_o), 32'(pend));
            if (pend && wb_valid_o) begin
                chk("wb_rd", 32'(wb_rd_o), 32'(exp_wb_rd));
                chk("wb_we", 32'(wb_we_o), 32'(exp_wb_we));
                chk("exc", 32'(exc_o), 32'(exp_wb_exc));
                if (exp_wb_exc) chk("exc_cause", 32'(exc_cause_o), 32'(exp_wb_cause));
                if (exp_wb_chkdata) chk("wb_data", wb_data_o, exp_wb_data);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_reset();
        check_en = 1'b0;
        rst_ni = 1'b0;
        valid_i = 1'b0;
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_req", 32'(dmem_req_o), 0);
        chk("rst_wb_valid", 32'(wb_valid_o), 0);
        chk("rst_wb_we", 32'(wb_we_o), 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_exc", 32'(exc_o), 0);
        chk("rst_be", 32'(dmem_be_o), 0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        exp_busy = 1'b0;
        exp_req = 1'b0;
        wb_push = wb_pop;
        check_en = 1'b1;
    endtask

    // gd/rvd < 0 means the bus never answers (timeout expected).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic we, input int gd, input int rvd,
                         input logic [31:0] rdat, input bit rst_in_wait);
        bit ld;
        ld = m_is_load(op);
        valid_i = 1'b1; mem_op_i = op; ex_i = a; store_data_i = d; rd_i = rd; rd_we_i = we;
        @(posedge clk); #1;
        valid_i = 1'b0;
        mem_op_i = 4'($urandom); ex_i = $urandom; store_data_i = $urandom;
        rd_i = 5'($urandom); rd_we_i = 1'($urandom);
        if (op == MEM_NONE) begin
            push_wb(a, rd, we, 1'b0, 4'd0, 1'b1);
            return;
        end
        if (TRAP && m_misaligned(op, a)) begin
            push_wb('0, rd, 1'b0, 1'b1, ld ? 4'd4 : 4'd6, 1'b0);
            return;
        end
        exp_busy = 1'b1; exp_req = 1'b1;
        exp_addr = {a[31:2], 2'b00}; exp_be = m_be(op, a);
        exp_we = !ld; exp_wdata = m_wdata(op, d);
        if (gd < 0) begin
            repeat (TMO) begin
                dmem_rvalid_i = 1'($urandom); dmem_rdata_i = $urandom;
                @(posedge clk); #1;
            end
            dmem_rvalid_i = 1'b0;
            exp_req = 1'b0; exp_busy = 1'b0;
            push_wb('0, rd, 1'b0, 1'b1, ld ? 4'd5 : 4'd7, 1'b0);
            return;
        end
        repeat (gd) begin
            dmem_rvalid_i = 1'($urandom); dmem_rdata_i = $urandom;
            @(posedge clk); #1;
        end
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        exp_req = 1'b0;
        if (!ld) begin
            exp_busy = 1'b0;
            push_wb('0, rd, 1'b0, 1'b0, 4'd0, 1'b0);
            return;
        end
        if (rst_in_wait) begin
            do_reset();
            dmem_rvalid_i = 1'b1; dmem_rdata_i = rdat;
            @(posedge clk); #1;
            dmem_rvalid_i = 1'b0;
            return;
        end
        if (rvd < 0) begin
            repeat (TMO) begin
                dmem_gnt_i = 1'($urandom);
                @(posedge clk); #1;
            end
            dmem_gnt_i = 1'b0;
            exp_busy = 1'b0;
            push_wb('0, rd, 1'b0, 1'b1, 4'd5, 1'b0);
            return;
        end
        repeat (rvd) begin
            dmem_gnt_i = 1'($urandom);
            @(posedge clk); #1;
        end
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdat;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
        exp_busy = 1'b0;
        push_wb(m_load(op, a, rdat), rd, we, 1'b0, 4'd0, 1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        do_reset();

        // ALU pass-through, then back-to-back
        issue(MEM_NONE, 32'h1234_5678, '0, 5'd5, 1'b1, 0, 0, '0, 1'b0);
        chk("lit_alu_data", wb_data_o, 32'h1234_5678);
        chk("lit_alu_rd", 32'(wb_rd_o), 5);
        for (int i = 0; i < 3; i++)
            issue(MEM_NONE, $urandom, '0, 5'(i + 1), 1'b1, 0, 0, '0, 1'b0);

        // SB lanes, immediate grant and delayed grant
        issue(MEM_SB, 32'h0000_1003, 32'h0000_00AB, 5'd1, 1'b0, 0, 0, '0, 1'b0);
        chk("lit_sb_addr", last_req_addr, 32'h0000_1000);
        chk("lit_sb_be", 32'(last_req_be), 32'b1000);
        chk("lit_sb_wdata", last_req_wdata, 32'hABAB_ABAB);
        issue(MEM_SB, 32'h0000_1003, 32'h0000_00AB, 5'd1, 1'b1, 3, 0, '0, 1'b0);
        chk("lit_sb_wb_we", 32'(wb_we_o), 0);

        // Loads
        issue(MEM_LB, 32'h0000_2001, '0, 5'd7, 1'b1, 1, 2, 32'h0000_80FF, 1'b0);
        chk("lit_lb", wb_data_o, 32'hFFFF_FF80);
        issue(MEM_LHU, 32'h0000_2002, '0, 5'd8, 1'b1, 0, 0, 32'hBEEF_1234, 1'b0);
        chk("lit_lhu", wb_data_o, 32'h0000_BEEF);

        // Grant timeout on a load
        issue(MEM_LW, 32'h0000_4000, '0, 5'd9, 1'b1, -1, 0, '0, 1'b0);
        chk("lit_tmo_exc", 32'(exc_o), 1);
        chk("lit_tmo_cause", 32'(exc_cause_o), 5);
        chk("lit_tmo_we", 32'(wb_we_o), 0);

        // Misaligned word store
        last_req_addr = '0;
        issue(MEM_SW, 32'h0000_3002, 32'hCAFE_F00D, 5'd3, 1'b0, 0, 0, '0, 1'b0);
        if (TRAP) begin
            chk("lit_mis_exc", 32'(exc_o), 1);
            chk("lit_mis_cause", 32'(exc_cause_o), 6);
            chk("lit_mis_noreq", last_req_addr, 0);
        end else begin
            chk("lit_mis_exc", 32'(exc_o), 0);
            chk("lit_mis_addr", last_req_addr, 32'h0000_3000);
            chk("lit_mis_be", 32'(last_req_be), 32'hF);
        end

        // Reset while waiting for read data; late rvalid must be ignored
        issue(MEM_LW, 32'h0000_5000, '0, 5'd4, 1'b1, 0, 0, 32'h1111_2222, 1'b1);
        chk("rst_mid_ready", 32'(ready_o), 1);
        chk("rst_mid_nowb", 32'(wb_valid_o), 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            int gd, rvd;
            op  = 4'($urandom_range(0, 8));
            gd  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            rvd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            issue(op, $urandom, $urandom, 5'($urandom), 1'($urandom), gd, rvd, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        chk("final_idle", 32'(ready_o), 1);
        @(negedge clk); #1;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
